// File: rtl/snitch_event_counter_pkg.sv
// Shared types and register layout for the cluster performance counter unit.
// Software and the testbench use these offsets and field positions as the register map.
package snitch_event_counter_pkg;

    // Per-core event strobes. The struct is packed MSB first, so retired_acc is bit 0.
    typedef struct packed {
        logic issue_core_to_fpu;
        logic issue_fpu_seq;
        logic issue_fpu;
        logic retired_instr;
        logic retired_load;
        logic retired_i;
        logic retired_acc;
    } core_events_t;

    localparam int unsigned NrEvents = $bits(core_events_t);

    typedef struct packed {
        logic       ovf;
        logic [2:0] evt_sel;
        logic       irq_en;
        logic       en;
    } evt_cnt_ctrl_t;

    localparam logic [1:0] CntCtrlOff = 2'd0;
    localparam logic [1:0] CntMaskOff = 2'd1;
    localparam logic [1:0] CntLoOff   = 2'd2;
    localparam logic [1:0] CntHiOff   = 2'd3;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned CtrlSelLsb   = 4;
    localparam int unsigned CtrlOvfBit   = 31;

    localparam int unsigned GlbFreezeBit = 0;
    localparam int unsigned GlbClearBit  = 1;

    function automatic logic [31:0] pack_ctrl(input evt_cnt_ctrl_t ctrl);
        return {ctrl.ovf, 24'b0, ctrl.evt_sel, 2'b0, ctrl.irq_en, ctrl.en};
    endfunction

endpackage

// File: rtl/snitch_event_counter_if.sv
// Word-addressed register port between the peripheral demux (master) and the counter unit (slave).
// Each request completes with a response one cycle later.
interface snitch_event_counter_if #(
    parameter int unsigned AddrWidth = 5
);
    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 rvalid;

    modport master (output req, we, addr, wdata, input rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/snitch_event_counter_slice.sv
// One programmable counter: CTRL/MASK state, the masked per-core popcount and the
// wrapping accumulator that sets the sticky overflow flag.
module snitch_event_counter_slice
    import snitch_event_counter_pkg::*;
#(
    parameter int unsigned NrCores  = 8,
    parameter int unsigned CntWidth = 48
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  core_events_t [NrCores-1:0] evt_i,
    input  logic                       freeze_i,
    input  logic                       clear_i,
    input  logic                       ctrl_we_i,
    input  logic                       mask_we_i,
    input  logic                       lo_we_i,
    input  logic                       hi_we_i,
    input  logic [31:0]                wdata_i,
    output evt_cnt_ctrl_t              ctrl_o,
    output logic [NrCores-1:0]         mask_o,
    output logic [CntWidth-1:0]        value_o,
    output logic                       irq_o
);

    localparam int unsigned IncWidth = $clog2(NrCores + 1);
    localparam int unsigned SumWidth = CntWidth + 1;
    localparam logic [2:0]  LastEvtSel = 3'(NrEvents - 1);

    evt_cnt_ctrl_t        ctrl_d, ctrl_q;
    logic [NrCores-1:0]   mask_d, mask_q;
    logic [CntWidth-1:0]  value_d, value_q;
    logic                 irq_d, irq_q;
    logic [IncWidth-1:0]  inc;
    logic [SumWidth-1:0]  sum;

    // The extra sum bit is the wrap indicator that feeds the overflow flag.
    always_comb begin
        inc = '0;
        if (ctrl_q.en && !freeze_i && (ctrl_q.evt_sel <= LastEvtSel)) begin
            for (int unsigned c = 0; c < NrCores; c++) begin
                inc = inc + IncWidth'(evt_i[c][ctrl_q.evt_sel] & mask_q[c]);
            end
        end
        sum = {1'b0, value_q} + SumWidth'(inc);
    end

    // A clear beats everything. A value write drops this cycle's increment.
    // The overflow set is applied after the W1C, so the set wins.
    always_comb begin
        ctrl_d  = ctrl_q;
        mask_d  = mask_q;
        value_d = value_q;
        irq_d   = ctrl_q.ovf & ctrl_q.irq_en;
        if (clear_i) begin
            value_d     = '0;
            ctrl_d.ovf  = 1'b0;
        end else begin
            if (ctrl_we_i) begin
                ctrl_d.en      = wdata_i[CtrlEnBit];
                ctrl_d.irq_en  = wdata_i[CtrlIrqEnBit];
                ctrl_d.evt_sel = wdata_i[CtrlSelLsb +: 3];
                if (wdata_i[CtrlOvfBit]) begin
                    ctrl_d.ovf = 1'b0;
                end
            end
            if (mask_we_i) begin
                mask_d = wdata_i[NrCores-1:0];
            end
            if (lo_we_i) begin
                value_d[31:0] = wdata_i;
            end else if (hi_we_i) begin
                value_d[CntWidth-1:32] = wdata_i[CntWidth-33:0];
            end else begin
                value_d = sum[CntWidth-1:0];
                if (sum[CntWidth]) begin
                    ctrl_d.ovf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            mask_q  <= '0;
            value_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            mask_q  <= mask_d;
            value_q <= value_d;
            irq_q   <= irq_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign mask_o  = mask_q;
    assign value_o = value_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/snitch_event_counter.sv
// Cluster performance counter unit. It registers the core event strobes, fans them out
// to the counter slices, and serves the register port with a shadowed VALUE_HI read.
module snitch_event_counter
    import snitch_event_counter_pkg::*;
#(
    parameter int unsigned NrCores    = 8,
    parameter int unsigned NrCounters = 4,
    parameter int unsigned CntWidth   = 48
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NrCores*NrEvents-1:0]   events_i,
    snitch_event_counter_if.slave         reg_if,
    output logic [NrCounters-1:0]         irq_o
);

    localparam int unsigned AddrWidth = $clog2(NrCounters * 4 + 1);
    localparam int unsigned IdxWidth  = AddrWidth - 2;
    localparam int unsigned HiWidth   = CntWidth - 32;
    localparam logic [AddrWidth-1:0] GlbAddr = AddrWidth'(NrCounters * 4);

    core_events_t [NrCores-1:0] evt_d, evt_q;
    logic                       freeze_d, freeze_q;
    logic [HiWidth-1:0]         shadow_d, shadow_q;
    logic [31:0]                rdata_d, rdata_q;
    logic                       rvalid_d, rvalid_q;

    logic [IdxWidth-1:0] idx;
    logic [1:0]          off;
    logic                wr, rd, glb_wr, clear_all;

    evt_cnt_ctrl_t       ctrl  [NrCounters];
    logic [NrCores-1:0]  mask  [NrCounters];
    logic [CntWidth-1:0] value [NrCounters];

    assign evt_d     = events_i;
    assign idx       = reg_if.addr[AddrWidth-1:2];
    assign off       = reg_if.addr[1:0];
    assign wr        = reg_if.req & reg_if.we;
    assign rd        = reg_if.req & ~reg_if.we;
    assign glb_wr    = wr && (reg_if.addr == GlbAddr);
    assign clear_all = glb_wr && reg_if.wdata[GlbClearBit];

    // The global address decodes to index NrCounters, so it never selects a slice.
    for (genvar i = 0; i < NrCounters; i++) begin : gen_slice
        logic sel;
        assign sel = wr && (idx == IdxWidth'(i));

        snitch_event_counter_slice #(
            .NrCores  (NrCores),
            .CntWidth (CntWidth)
        ) i_slice (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .evt_i     (evt_q),
            .freeze_i  (freeze_q),
            .clear_i   (clear_all),
            .ctrl_we_i (sel && (off == CntCtrlOff)),
            .mask_we_i (sel && (off == CntMaskOff)),
            .lo_we_i   (sel && (off == CntLoOff)),
            .hi_we_i   (sel && (off == CntHiOff)),
            .wdata_i   (reg_if.wdata),
            .ctrl_o    (ctrl[i]),
            .mask_o    (mask[i]),
            .value_o   (value[i]),
            .irq_o     (irq_o[i])
        );
    end

    // A VALUE_LO read captures the matching high half so a following HI read is coherent.
    always_comb begin
        rdata_d  = '0;
        shadow_d = shadow_q;
        freeze_d = freeze_q;
        rvalid_d = reg_if.req;
        if (glb_wr) begin
            freeze_d = reg_if.wdata[GlbFreezeBit];
        end
        if (rd) begin
            if (reg_if.addr == GlbAddr) begin
                rdata_d = 32'(freeze_q);
            end else begin
                for (int unsigned i = 0; i < NrCounters; i++) begin
                    if (idx == IdxWidth'(i)) begin
                        case (off)
                            CntCtrlOff: rdata_d = pack_ctrl(ctrl[i]);
                            CntMaskOff: rdata_d = 32'(mask[i]);
                            CntLoOff: begin
                                rdata_d  = value[i][31:0];
                                shadow_d = value[i][CntWidth-1:32];
                            end
                            CntHiOff:   rdata_d = 32'(shadow_q);
                            default:    rdata_d = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_q    <= '0;
            freeze_q <= 1'b0;
            shadow_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            evt_q    <= evt_d;
            freeze_q <= freeze_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign reg_if.rdata  = rdata_q;
    assign reg_if.rvalid = rvalid_q;

endmodule

// File: tb/tb_snitch_event_counter.sv
// Scoreboard bench for snitch_event_counter: a behavioural register/counter model predicts
// every response, and a negedge monitor compares rvalid, rdata and irq_o.
module tb_snitch_event_counter;
    import snitch_event_counter_pkg::*;

    localparam int NrCores    = 8;
    localparam int NrCounters = 4;
    localparam int CntWidth   = 48;
    localparam int AddrWidth  = 5;
    localparam int EvW        = NrCores * 7;
    localparam logic [4:0] GlbAddr = 5'd16;
    localparam longint unsigned CntMod = 64'd1 << CntWidth;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [EvW-1:0]        events = '0;
    logic [NrCounters-1:0] irq;

    snitch_event_counter_if #(.AddrWidth(AddrWidth)) reg_if ();

    snitch_event_counter #(
        .NrCores    (NrCores),
        .NrCounters (NrCounters),
        .CntWidth   (CntWidth)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .events_i (events),
        .reg_if   (reg_if),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    longint unsigned m_val    [NrCounters];
    bit              m_en     [NrCounters];
    bit              m_irq_en [NrCounters];
    bit              m_ovf    [NrCounters];
    bit [2:0]        m_sel    [NrCounters];
    bit [7:0]        m_mask   [NrCounters];
    bit              m_freeze;
    longint unsigned m_shadow;
    bit [EvW-1:0]    m_evt_prev;
    bit [NrCounters-1:0] m_irq;
    bit              exp_valid;
    logic [31:0]     exp_q [$];

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NrCounters; i++) begin
            m_val[i] = 0; m_en[i] = 0; m_irq_en[i] = 0; m_ovf[i] = 0; m_sel[i] = 0; m_mask[i] = 0;
        end
        m_freeze = 0; m_shadow = 0; m_evt_prev = '0; m_irq = '0; exp_valid = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int idx = int'(a) / 4;
        int off = int'(a) % 4;
        if (a == GlbAddr) return {31'b0, m_freeze};
        if (idx >= NrCounters) return 32'h0;
        case (off)
            0:       return {m_ovf[idx], 24'b0, m_sel[idx], 2'b0, m_irq_en[idx], m_en[idx]};
            1:       return 32'(m_mask[idx]);
            2:       return 32'(m_val[idx]);
            default: return 32'(m_shadow);
        endcase
    endfunction

    // One clock edge of the reference: responses from the pre-edge state, then the update.
    task automatic model_edge();
        bit req, we, clear, hit;
        logic [4:0] a;
        logic [31:0] d;
        int idx, off, inc;
        longint unsigned total;
        if (rst) begin
            model_reset();
            return;
        end
        req = reg_if.req; we = reg_if.we; a = reg_if.addr; d = reg_if.wdata;
        idx = int'(a) / 4; off = int'(a) % 4;
        exp_valid = req;
        if (req) exp_q.push_back(we ? 32'h0 : model_read(a));
        if (req && !we && idx < NrCounters && off == 2) m_shadow = m_val[idx] >> 32;
        clear = req && we && (a == GlbAddr) && d[1];
        for (int i = 0; i < NrCounters; i++) begin
            m_irq[i] = m_ovf[i] & m_irq_en[i];
            inc = 0;
            if (m_en[i] && !m_freeze && m_sel[i] < 7)
                for (int c = 0; c < NrCores; c++)
                    if (m_evt_prev[c*7 + int'(m_sel[i])] && m_mask[i][c]) inc++;
            hit = req && we && (idx == i);
            if (clear) begin
                m_val[i] = 0; m_ovf[i] = 0;
            end else begin
                if (hit && off == 0) begin
                    m_en[i] = d[0]; m_irq_en[i] = d[1]; m_sel[i] = d[6:4];
                    if (d[31]) m_ovf[i] = 0;
                end
                if (hit && off == 1) m_mask[i] = d[7:0];
                if (hit && off == 2) m_val[i] = (m_val[i] & ~64'hFFFF_FFFF) | 64'(d);
                else if (hit && off == 3) m_val[i] = (m_val[i] & 64'hFFFF_FFFF) | (64'(d[15:0]) << 32);
                else begin
                    total = m_val[i] + 64'(inc);
                    if (total >= CntMod) begin
                        total = total - CntMod;
                        m_ovf[i] = 1;
                    end
                    m_val[i] = total;
                end
            end
        end
        if (req && we && a == GlbAddr) m_freeze = d[0];
        m_evt_prev = events;
    endtask

    task automatic applyStimulus(input bit req, input bit we, input logic [4:0] a,
                                 input logic [31:0] d, input logic [EvW-1:0] ev);
        reg_if.req = req; reg_if.we = we; reg_if.addr = a; reg_if.wdata = d; events = ev;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic [EvW-1:0] ev = '0);
        applyStimulus(1, 1, a, d, ev);
    endtask

    task automatic rd_reg(input logic [4:0] a, input logic [EvW-1:0] ev = '0);
        applyStimulus(1, 0, a, 32'h0, ev);
    endtask

    task automatic idle(input int n, input logic [EvW-1:0] ev = '0);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 5'd0, 32'h0, ev);
    endtask

    function automatic logic [EvW-1:0] strobe(input int b, input logic [7:0] cores);
        logic [EvW-1:0] r = '0;
        for (int c = 0; c < NrCores; c++) if (cores[c]) r[c*7 + b] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rvalid", 64'(reg_if.rvalid), 64'(exp_valid));
            if (exp_valid && exp_q.size() > 0) checkOutput("rdata", 64'(reg_if.rdata), 64'(exp_q.pop_front()));
            checkOutput("irq", 64'(irq), 64'(m_irq));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [EvW-1:0] all_b3, one_b3;
        all_b3 = strobe(3, 8'hFF);
        one_b3 = strobe(3, 8'h01);
        reg_if.req = 0; reg_if.we = 0; reg_if.addr = '0; reg_if.wdata = '0;
        model_reset();
        idle(2);
        rst = 1'b0;
        for (int a = 0; a <= 20; a++) rd_reg(5'(a));

        // Counting with full and partial core masks.
        wr_reg(5'd0, 32'h31); wr_reg(5'd1, 32'hFF);
        idle(10, all_b3); idle(2); rd_reg(5'd2);
        wr_reg(5'd2, 0); wr_reg(5'd3, 0); wr_reg(5'd1, 32'h05);
        idle(10, all_b3); idle(2); rd_reg(5'd2); rd_reg(5'd3);

        // Wrap-around, sticky ovf, irq, then W1C.
        wr_reg(5'd1, 32'h01); wr_reg(5'd3, 32'hFFFF); wr_reg(5'd2, 32'hFFFF_FFFE); wr_reg(5'd0, 32'h33);
        idle(3, one_b3); idle(3); rd_reg(5'd2); rd_reg(5'd3); rd_reg(5'd0);
        wr_reg(5'd0, 32'h8000_0033); idle(3); rd_reg(5'd0);

        // Shadowed HI read across a carry.
        wr_reg(5'd0, 32'h31); wr_reg(5'd3, 32'h12); wr_reg(5'd2, 32'hFFFF_FFFF);
        rd_reg(5'd2, one_b3); idle(2); rd_reg(5'd3); rd_reg(5'd2); rd_reg(5'd3);

        // Freeze, write-vs-increment, clear_all-vs-increment.
        wr_reg(5'd1, 32'hFF); wr_reg(5'd16, 32'h1);
        idle(5, all_b3); idle(2); rd_reg(5'd2); rd_reg(5'd16); wr_reg(5'd16, 32'h0);
        idle(3, all_b3); wr_reg(5'd2, 32'd100, all_b3); idle(3); rd_reg(5'd2);
        idle(3, all_b3); wr_reg(5'd16, 32'h2); idle(2); rd_reg(5'd2); rd_reg(5'd0);

        // Out-of-range event select never counts.
        wr_reg(5'd0, 32'h71); idle(5, {EvW{1'b1}}); idle(2); rd_reg(5'd2);

        // Randomised traffic across all counters.
        for (int i = 0; i < NrCounters; i++) begin
            wr_reg(5'(i*4), 32'h1 | (32'($urandom_range(0, 7)) << 4));
            wr_reg(5'(i*4 + 1), $urandom);
        end
        for (int k = 0; k < 400; k++) begin
            logic [EvW-1:0] ev;
            int op;
            ev = {$urandom, $urandom};
            op = $urandom_range(0, 9);
            if (op < 3) rd_reg(5'($urandom_range(0, 31)), ev);
            else if (op == 3) wr_reg(5'($urandom_range(0, 31)), $urandom & 32'h8000_0073, ev);
            else if (op == 4 && $urandom_range(0, 3) == 0) wr_reg(5'($urandom_range(0, 31)), $urandom, ev);
            else idle(1, ev);
        end

        // Asynchronous reset mid-count with an interrupt pending and a response in flight.
        wr_reg(5'd16, 32'h0); wr_reg(5'd1, 32'h01); wr_reg(5'd3, 32'hFFFF);
        wr_reg(5'd2, 32'hFFFF_FFFF); wr_reg(5'd0, 32'h33);
        idle(4, one_b3);
        checkOutput("irq_before_reset", 64'(irq[0]), 64'd1);
        rd_reg(5'd2, one_b3);
        #1 rst = 1'b1;
        model_reset();
        #1;
        checkOutput("async_rst_irq", 64'(irq), 64'd0);
        checkOutput("async_rst_rvalid", 64'(reg_if.rvalid), 64'd0);
        checkOutput("async_rst_rdata", 64'(reg_if.rdata), 64'd0);
        idle(2, one_b3);
        rst = 1'b0;
        idle(1);
        for (int a = 0; a <= 16; a++) rd_reg(5'(a));
        idle(2);
        #6;
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
